irq_ctl: RTL and testbench

//  Parametrised interrupt controller in front of the 65C02 core's IRQ/NMI pins.
//  - Synchronises NCH external request lines and one NMI line.
//  - Latches pending requests, per-channel edge or level mode, with a mask register.
//  - Drives the core's IRQ/NMI inputs.
//  - Supplies a prioritised vector address, latched on the core's vector-fetch ack.
//  - Mask and pending registers are CPU-accessible through a small register port.

---
 rtl/irq_pkg.sv | 21 ++
 rtl/irq_sync_edge.sv | 38 +++
 rtl/irq_ctl.sv | 187 ++++++++++++++++++
 tb/tb_irq_ctl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg
//    Shared definitions for the interrupt controller in front of the 65C02
//    IRQ/NMI pins: register-port addresses, vector width and the largest
//    supported channel count.
package irq_pkg;

   // Register port addresses
   localparam logic [1:0] REG_MASK_L = 2'd0;
   localparam logic [1:0] REG_MASK_H = 2'd1;
   localparam logic [1:0] REG_PEND_L = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   // Vector address width (65C02 address bus)
   localparam int VEC_W = 16;

   // Largest channel count the register map can expose
   localparam int MAX_NCH = 16;

   typedef logic [VEC_W-1:0] vec_t;

endpackage : irq_pkg

// File: rtl/irq_sync_edge.sv
// irq_sync_edge
//    Brings one asynchronous request line into the clk domain through a
//    chain of SYNC_STAGES flops, keeps one more flop of history and flags
//    the cycle in which the synchronised line goes from 0 to 1.
// Ports
//    clk       in  1  CPU clock
//    rst       in  1  asynchronous active-high reset
//    async_in  in  1  raw request line
//    synced    out 1  synchronised level
//    rise      out 1  synchronised 0->1 transition, one cycle wide
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic synced,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Synchroniser chain plus one history flop for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];
   assign rise   = synced & ~prev_q;

endmodule : irq_sync_edge

// File: rtl/irq_ctl.sv
// irq_ctl
//    Interrupt controller for the 65C02 core. Synchronises NCH request lines
//    and one NMI line, latches them as pending (edge or level per channel),
//    masks them, drives the core's IRQ/NMI pins and returns a prioritised
//    vector address that is latched when the core acknowledges a vector
//    fetch. Mask, pending and status are visible through a 4-entry port.
// Ports
//    clk        in  1    CPU clock
//    RST        in  1    asynchronous active-high reset
//    irq_in     in  NCH  raw request lines, active high
//    nmi_in     in  1    raw NMI, rising-edge sensitive
//    sel        in  1    register port select
//    we         in  1    register write strobe (valid with sel)
//    addr       in  2    register index
//    di         in  8    register write data
//    dout       out 8    register read data, combinational from addr
//    ack        in  1    vector-fetch acknowledge pulse
//    irq_out    out 1    to core IRQ
//    nmi_out    out 1    to core NMI
//    vec        out 16   latched vector address
//    vec_valid  out 1    set once a vector has been latched
module irq_ctl
   import irq_pkg::*;
#(
   parameter int          NCH         = 8,
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] EDGE_MASK   = 16'h00FF,
   parameter logic [15:0] VEC_BASE    = 16'hFF00,
   parameter logic [15:0] NMI_VEC     = 16'hFFFA
) (
   input  logic             clk,
   input  logic             RST,
   input  logic [NCH-1:0]   irq_in,
   input  logic             nmi_in,
   input  logic             sel,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [7:0]       di,
   output logic [7:0]       dout,
   input  logic             ack,
   output logic             irq_out,
   output logic             nmi_out,
   output logic [VEC_W-1:0] vec,
   output logic             vec_valid
);

   // The NMI is carried as bit NCH of the pending vector and is always
   // edge-type, so channels and NMI share one set/clear equation.
   localparam logic [NCH:0]  EDGE_ALL = {1'b1, EDGE_MASK[NCH-1:0]};
   localparam vec_t          SPUR_VEC = VEC_BASE + VEC_W'(2 * NCH);

   logic [NCH:0]   raw_all;
   logic [NCH:0]   synced_all;
   logic [NCH:0]   rise_all;
   logic [NCH:0]   pend_q;
   logic [NCH:0]   pend_d;
   logic [NCH:0]   clr;
   logic [NCH-1:0] mask_q;
   logic [NCH-1:0] mask_d;
   logic [NCH-1:0] masked;
   logic           nmi_pend;
   logic           win_any;
   logic [3:0]     win_idx;
   logic [3:0]     last_win;
   logic           reg_wr;
   logic           mask_wr;
   logic [15:0]    di_pad;
   logic [15:0]    wr_word;
   logic [15:0]    wr_lanes;
   logic [15:0]    mask_rd;
   logic [7:0]     pend_lo;

   assign raw_all  = {nmi_in, irq_in};
   assign nmi_pend = pend_q[NCH];
   assign masked   = pend_q[NCH-1:0] & mask_q;
   assign reg_wr   = sel & we;
   assign di_pad   = {8'h00, di};

   generate
      for (genvar g = 0; g <= NCH; g++) begin : g_sync
         irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
         ) u_sync (
            .clk      (clk),
            .rst      (RST),
            .async_in (raw_all[g]),
            .synced   (synced_all[g]),
            .rise     (rise_all[g])
         );
      end
   endgenerate

   // Priority encoder: scanning downward leaves the lowest set index
   always_comb begin
      win_any = 1'b0;
      win_idx = 4'd0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (masked[i]) begin
            win_any = 1'b1;
            win_idx = 4'(i);
         end
      end
   end

   // Clear requests from W1C writes and from the serviced source. The set
   // term is OR-ed in after the clear, so a coincident edge keeps the bit.
   // Level channels ignore clears entirely and just follow their line.
   always_comb begin
      clr = '0;
      if (reg_wr && (addr == REG_PEND_L)) begin
         clr[NCH-1:0] = di_pad[NCH-1:0];
      end
      if (ack) begin
         if (nmi_pend) begin
            clr[NCH] = 1'b1;
         end else if (win_any) begin
            for (int i = 0; i < NCH; i++) begin
               if (4'(i) == win_idx) begin
                  clr[i] = 1'b1;
               end
            end
         end
      end
      pend_d = (EDGE_ALL & (rise_all | (pend_q & ~clr))) |
               (~EDGE_ALL & synced_all);
   end

   // Mask writes: MASK_L lands on bits 7:0, MASK_H on bits 15:8
   always_comb begin
      mask_wr  = reg_wr && ((addr == REG_MASK_L) || (addr == REG_MASK_H));
      wr_word  = (addr == REG_MASK_H) ? {di, 8'h00} : {8'h00, di};
      wr_lanes = (addr == REG_MASK_H) ? 16'hFF00 : 16'h00FF;
      mask_d   = mask_q;
      for (int i = 0; i < NCH; i++) begin
         if (mask_wr && wr_lanes[i]) begin
            mask_d[i] = wr_word[i];
         end
      end
   end

   // Pending/mask state, registered pin drivers and the ack-time vector
   // latch. Arbitration reads registered state, so a mask write in the ack
   // cycle does not affect that ack.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         pend_q    <= '0;
         mask_q    <= '0;
         irq_out   <= 1'b0;
         nmi_out   <= 1'b0;
         vec       <= NMI_VEC;
         vec_valid <= 1'b0;
         last_win  <= 4'd0;
      end else begin
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         irq_out <= |masked;
         nmi_out <= nmi_pend;
         if (ack) begin
            vec_valid <= 1'b1;
            if (nmi_pend) begin
               vec <= NMI_VEC;
            end else if (win_any) begin
               vec      <= VEC_BASE + {11'b0, win_idx, 1'b0};
               last_win <= win_idx;
            end else begin
               vec <= SPUR_VEC;
            end
         end
      end
   end

   assign mask_rd = 16'(mask_q);
   assign pend_lo = 8'(pend_q[NCH-1:0]);

   // Register read mux
   always_comb begin
      dout = 8'h00;
      case (addr)
         REG_MASK_L: dout = mask_rd[7:0];
         REG_MASK_H: dout = mask_rd[15:8];
         REG_PEND_L: dout = pend_lo;
         REG_STATUS: dout = {nmi_pend, vec_valid, 2'b00, last_win};
         default:    dout = 8'h00;
      endcase
   end

endmodule : irq_ctl

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl
//    Self-checking bench for irq_ctl (NCH=8, channel 3 level, rest edge).
//    A behavioural reference model tracks what the controller should show
//    each cycle; directed scenarios and a randomized phase are compared
//    against it and against hand-derived constants.
module tb_irq_ctl;

   localparam int          NCH      = 8;
   localparam logic [15:0] EDGE     = 16'h00F7;
   localparam logic [15:0] VB       = 16'hFF00;
   localparam logic [15:0] NV       = 16'hFFFA;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  irq_in = '0;
   logic        nmi_in = 1'b0;
   logic        sel = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [7:0]  di = '0;
   logic [7:0]  dout;
   logic        ack = 1'b0;
   logic        irq_out;
   logic        nmi_out;
   logic [15:0] vec;
   logic        vec_valid;

   int vectors = 0;
   int miscompares = 0;

   irq_ctl #(
      .NCH         (NCH),
      .SYNC_STAGES (2),
      .EDGE_MASK   (EDGE),
      .VEC_BASE    (VB),
      .NMI_VEC     (NV)
   ) dut (
      .clk       (clk),
      .RST       (RST),
      .irq_in    (irq_in),
      .nmi_in    (nmi_in),
      .sel       (sel),
      .we        (we),
      .addr      (addr),
      .di        (di),
      .dout      (dout),
      .ack       (ack),
      .irq_out   (irq_out),
      .nmi_out   (nmi_out),
      .vec       (vec),
      .vec_valid (vec_valid)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [7:0]  m_pend, m_mask;
   logic        m_nmi, m_irq_out, m_nmi_out, m_vv;
   logic [15:0] m_vec;
   logic [3:0]  m_last;
   logic [8:0]  hist [0:2];

   // Reference model: a line seen at edge e reaches the pending logic as
   // "current level" two edges later; the sample one edge older tells
   // whether that was a 0->1 step.
   always @(posedge clk or posedge RST) begin
      if (RST) begin
         m_pend    <= '0;
         m_mask    <= '0;
         m_nmi     <= 1'b0;
         m_irq_out <= 1'b0;
         m_nmi_out <= 1'b0;
         m_vec     <= NV;
         m_vv      <= 1'b0;
         m_last    <= 4'd0;
         for (int k = 0; k < 3; k++) hist[k] <= '0;
      end else begin : model_step
         automatic logic [8:0] now_lvl = hist[1];
         automatic logic [8:0] old_lvl = hist[2];
         automatic logic [7:0] active  = m_pend & m_mask;
         automatic int         winner  = -1;
         automatic logic [7:0] cleared = '0;
         automatic logic [7:0] pend_next = '0;
         automatic logic       nmi_taken = 1'b0;
         for (int n = 7; n >= 0; n--) if (active[n]) winner = n;
         m_irq_out <= (active != 8'h00);
         m_nmi_out <= m_nmi;
         if (ack) begin
            m_vv <= 1'b1;
            if (m_nmi) begin
               m_vec     <= NV;
               nmi_taken = 1'b1;
            end else if (winner >= 0) begin
               m_vec           <= VB + 16'(2 * winner);
               m_last          <= 4'(winner);
               cleared[winner] = 1'b1;
            end else begin
               m_vec <= VB + 16'(2 * NCH);
            end
         end
         if (sel && we && addr == 2'd2) cleared = cleared | di;
         if (sel && we && addr == 2'd0) m_mask <= di;
         for (int n = 0; n < 8; n++) begin
            if (EDGE[n])
               pend_next[n] = (now_lvl[n] && !old_lvl[n]) || (m_pend[n] && !cleared[n]);
            else
               pend_next[n] = now_lvl[n];
         end
         m_pend <= pend_next;
         m_nmi  <= (now_lvl[8] && !old_lvl[8]) || (m_nmi && !nmi_taken);
         hist[2] <= hist[1];
         hist[1] <= hist[0];
         hist[0] <= {nmi_in, irq_in};
      end
   end

   function automatic logic [7:0] expDout(input logic [1:0] a);
      case (a)
         2'd0:    return m_mask;
         2'd1:    return 8'h00;
         2'd2:    return m_pend;
         default: return {m_nmi, m_vv, 2'b00, m_last};
      endcase
   endfunction

   // Compare every output against the reference model
   task automatic checkOutput(input string tag);
      vectors++;
      assert (irq_out === m_irq_out) else begin
         miscompares++;
         $error("[TB] FAIL %s irq_out got %b want %b", tag, irq_out, m_irq_out);
      end
      vectors++;
      assert (nmi_out === m_nmi_out) else begin
         miscompares++;
         $error("[TB] FAIL %s nmi_out got %b want %b", tag, nmi_out, m_nmi_out);
      end
      vectors++;
      assert (vec === m_vec) else begin
         miscompares++;
         $error("[TB] FAIL %s vec got %h want %h", tag, vec, m_vec);
      end
      vectors++;
      assert (vec_valid === m_vv) else begin
         miscompares++;
         $error("[TB] FAIL %s vec_valid got %b want %b", tag, vec_valid, m_vv);
      end
      vectors++;
      assert (dout === expDout(addr)) else begin
         miscompares++;
         $error("[TB] FAIL %s dout got %h want %h", tag, dout, expDout(addr));
      end
   endtask

   // Compare one observed value against a hand-derived constant
   task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("[TB] FAIL %s got %h want %h", tag, got, want);
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      @(negedge clk);
      checkOutput(tag);
   endtask

   task automatic regWrite(input logic [1:0] a, input logic [7:0] d);
      sel = 1'b1; we = 1'b1; addr = a; di = d;
      tick("wr");
      sel = 1'b0; we = 1'b0;
   endtask

   task automatic regRead(input logic [1:0] a, input logic [7:0] want, input string tag);
      addr = a;
      #1;
      checkValue(tag, {8'h00, dout}, {8'h00, want});
   endtask

   task automatic ackPulse(input string tag);
      ack = 1'b1;
      tick(tag);
      ack = 1'b0;
   endtask

   // Randomized traffic: line toggles, register accesses, acks, rare resets
   task automatic applyStimulus(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         for (int b = 0; b < 8; b++)
            if ($urandom_range(7, 0) == 0) irq_in[b] = ~irq_in[b];
         if ($urandom_range(15, 0) == 0) nmi_in = ~nmi_in;
         ack  = ($urandom_range(5, 0) == 0);
         addr = 2'($urandom_range(3, 0));
         di   = 8'($urandom_range(255, 0));
         sel  = ($urandom_range(3, 0) == 0);
         we   = sel;
         RST  = ($urandom_range(149, 0) == 0);
         tick("rand");
      end
      RST = 1'b0; ack = 1'b0; sel = 1'b0; we = 1'b0;
      irq_in = '0; nmi_in = 1'b0;
      repeat (5) tick("rand_drain");
   endtask

   initial begin : main
      automatic int nmi_hits = 0;

      // Reset asserted in the middle of traffic, ack ignored while in reset
      repeat (2) @(negedge clk);
      RST = 1'b0;
      regWrite(2'd0, 8'h5A);
      irq_in = 8'h12; nmi_in = 1'b1;
      repeat (5) tick("traffic");
      ack = 1'b1;
      tick("ack_before_rst");
      RST = 1'b1;
      #1;
      addr = 2'd0;
      #1;
      checkValue("rst_irq_out", {15'b0, irq_out}, 16'h0000);
      checkValue("rst_nmi_out", {15'b0, nmi_out}, 16'h0000);
      checkValue("rst_vec", vec, NV);
      checkValue("rst_mask", {8'h00, dout}, 16'h0000);
      tick("rst_hold_ack");
      checkValue("rst_vec_valid", {15'b0, vec_valid}, 16'h0000);
      ack = 1'b0; irq_in = '0; nmi_in = 1'b0;
      @(negedge clk);
      RST = 1'b0;
      tick("post_rst");

      // Mask and single-channel service
      regWrite(2'd0, 8'h04);
      irq_in[2] = 1'b1;
      tick("mask_pulse");
      irq_in[2] = 1'b0;
      repeat (3) tick("mask_wait");
      checkValue("mask_irq_out", {15'b0, irq_out}, 16'h0001);
      ackPulse("mask_ack");
      checkValue("mask_vec", vec, 16'hFF04);
      tick("mask_after");
      checkValue("mask_irq_clear", {15'b0, irq_out}, 16'h0000);

      // Priority: NMI, then channel 1, then channel 5
      regWrite(2'd0, 8'hFF);
      irq_in[5] = 1'b1; irq_in[1] = 1'b1; nmi_in = 1'b1;
      repeat (4) tick("prio_wait");
      checkValue("prio_nmi_out", {15'b0, nmi_out}, 16'h0001);
      ackPulse("prio_ack1");
      checkValue("prio_vec1", vec, 16'hFFFA);
      tick("prio_gap");
      ackPulse("prio_ack2");
      checkValue("prio_vec2", vec, 16'hFF02);
      tick("prio_gap");
      ackPulse("prio_ack3");
      checkValue("prio_vec3", vec, 16'hFF0A);
      irq_in = '0; nmi_in = 1'b0;
      repeat (4) tick("prio_drain");

      // Level channel 3: survives ack and W1C, follows its line
      irq_in[3] = 1'b1;
      repeat (4) tick("lvl_wait");
      checkValue("lvl_irq_out", {15'b0, irq_out}, 16'h0001);
      ackPulse("lvl_ack");
      checkValue("lvl_vec", vec, 16'hFF06);
      repeat (2) tick("lvl_hold");
      checkValue("lvl_irq_hold", {15'b0, irq_out}, 16'h0001);
      regWrite(2'd2, 8'h08);
      regRead(2'd2, 8'h08, "lvl_w1c_ignored");
      irq_in[3] = 1'b0;
      repeat (4) tick("lvl_drop");
      checkValue("lvl_irq_drop", {15'b0, irq_out}, 16'h0000);

      // Collision: edge on ch0 lands in the same cycle as its W1C
      irq_in[0] = 1'b1;
      tick("col_first");
      irq_in[0] = 1'b0;
      repeat (3) tick("col_first_wait");
      regRead(2'd2, 8'h01, "col_pend_set");
      irq_in[0] = 1'b1;
      tick("col_edge1");
      irq_in[0] = 1'b0;
      tick("col_edge2");
      regWrite(2'd2, 8'h01);
      regRead(2'd2, 8'h01, "col_set_wins");
      regWrite(2'd2, 8'hFF);
      regRead(2'd2, 8'h00, "col_cleared");
      tick("col_settle");
      ackPulse("spur_ack");
      checkValue("spur_vec", vec, 16'hFF10);

      // NMI held high across three acks: serviced exactly once
      nmi_in = 1'b1;
      repeat (4) tick("nmi_wait");
      for (int k = 0; k < 3; k++) begin
         ackPulse("nmi_ack");
         if (vec == 16'hFFFA) nmi_hits++;
         tick("nmi_gap");
      end
      checkValue("nmi_once", 16'(nmi_hits), 16'd1);
      checkValue("nmi_out_low", {15'b0, nmi_out}, 16'h0000);
      nmi_in = 1'b0;
      repeat (3) tick("nmi_drop");

      applyStimulus(600);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_irq_ctl
